// File: rtl/fixedpoint_addacc.sv
// fixedpoint_addacc: N-lane two-stage fixed-point add / accumulate with ready/valid flow control.
// Build option FIXEDPOINT_ADDACC_SAT_EN selects saturating results (default: two's-complement wrap). Rev 1.0
`default_nettype none

module fixedpoint_addacc #(
   parameter int N      = 4,
   parameter int BA     = 32,
   parameter int BB     = 32,
   parameter int BOUT   = 32,
   parameter int BSHIFT = 4
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                mode,
   input  logic                in_last,
   input  logic [BSHIFT-1:0]   shift,
   input  logic [N*BA-1:0]     a,
   input  logic [N*BB-1:0]     b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*BOUT-1:0]   out,
   output logic [N-1:0]        ovf
);

   localparam int C_SH_MAX = (1 << BSHIFT) - 1;
   localparam int C_BBS    = BB + C_SH_MAX;
   localparam int C_BM     = (BA > C_BBS) ? BA : C_BBS;
   localparam int BI       = ((C_BM > BOUT) ? C_BM : BOUT) + 2;

   logic w_en;
   logic r_s1_valid;
   logic r_s1_mode;
   logic r_s1_last;
   logic r_out_valid;

   assign w_en      = !r_out_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_mode   <= 1'b0;
         r_s1_last   <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_en) begin
         r_s1_valid  <= in_valid;
         r_s1_mode   <= mode;
         r_s1_last   <= in_last;
         r_out_valid <= r_s1_valid;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [BI-1:0]   w_a_ext;
      logic [BI-1:0]   w_b_ext;
      logic [BI-1:0]   w_acc_ext;
      logic [BI-1:0]   w_sum;
      logic [BOUT-1:0] w_res;
      logic            w_ovf;
      logic [BI-1:0]   r_a;
      logic [BI-1:0]   r_b;
      logic [BOUT-1:0] r_acc;
      logic [BOUT-1:0] r_res;
      logic            r_ovf;

      assign w_a_ext   = {{(BI-BA){a[i*BA+BA-1]}}, a[i*BA +: BA]};
      assign w_b_ext   = {{(BI-BB){b[i*BB+BB-1]}}, b[i*BB +: BB]};
      // Accumulator is read and written in S2, so consecutive accumulate beats chain with no bubble.
      assign w_acc_ext = r_s1_mode ? {{(BI-BOUT){r_acc[BOUT-1]}}, r_acc} : '0;
      assign w_sum     = w_acc_ext + r_a + r_b;

`ifdef FIXEDPOINT_ADDACC_SAT_EN
      logic [BI-BOUT:0] w_hi;
      assign w_hi = w_sum[BI-1:BOUT-1];

      always_comb begin
         w_res = w_sum[BOUT-1:0];
         w_ovf = 1'b0;
         if (!((&w_hi) || !(|w_hi))) begin
            w_ovf = 1'b1;
            w_res = w_sum[BI-1] ? {1'b1, {(BOUT-1){1'b0}}} : {1'b0, {(BOUT-1){1'b1}}};
         end
      end
`else
      assign w_res = w_sum[BOUT-1:0];
      assign w_ovf = 1'b0;
`endif

      always_ff @(posedge clk) begin
         if (!clr_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
         end else if (w_en) begin
            r_a <= w_a_ext;
            r_b <= w_b_ext << shift;
            if (r_s1_valid) begin
               r_res <= w_res;
               r_ovf <= w_ovf;
               if (r_s1_mode) begin
                  r_acc <= r_s1_last ? '0 : w_res;
               end
            end
         end
      end

      assign out[i*BOUT +: BOUT] = r_res;
      assign ovf[i]              = r_ovf;
   end

endmodule

`default_nettype wire
